// File: rtl/hpdmc_ddrwr_ctl.sv
// Write-burst sequencer for the DDR16 output datapath: DQS preamble, data burst,
// postamble and write recovery, feeding the D0/D1/CE inputs of the DQ/DM/DQS output registers.
module hpdmc_ddrwr_ctl #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned WR_LAT    = 1,
  parameter int unsigned TWR       = 2
) (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        write,
  output logic        ready,
  output logic        wr_err,
  input  logic [31:0] din,
  input  logic [3:0]  dmask,
  output logic        data_ack,
  output logic [15:0] dq_d0,
  output logic [15:0] dq_d1,
  output logic [1:0]  dm_d0,
  output logic [1:0]  dm_d1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        dqs_en,
  output logic        idle
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAT     = 3'd1,
    S_PRE     = 3'd2,
    S_BURST   = 3'd3,
    S_POST    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  // Counter preloads; the guarded forms keep the unused cases from underflowing.
  localparam logic [3:0] LAT_INIT   = 4'((WR_LAT >= 32'd2) ? (WR_LAT - 32'd2) : 32'd0);
  localparam logic [3:0] BURST_INIT = 4'((BURST_LEN >= 32'd1) ? (BURST_LEN - 32'd1) : 32'd0);
  localparam logic [3:0] TWR_INIT   = 4'((TWR >= 32'd1) ? (TWR - 32'd1) : 32'd0);
  localparam bit         LAT_SKIP   = (WR_LAT == 32'd1);
  localparam bit         TWR_ZERO   = (TWR == 32'd0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dq_d0_q, dq_d0_d;
  logic [15:0] dq_d1_q, dq_d1_d;
  logic [1:0]  dm_d0_q, dm_d0_d;
  logic [1:0]  dm_d1_q, dm_d1_d;
  logic        dq_oe_q, dq_oe_d;
  logic        dqs_oe_q, dqs_oe_d;
  logic        dqs_en_q, dqs_en_d;
  logic        ready_s;
  logic        ack_s;

  // Next-state, counter and combinational handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_s   = 1'b0;
    ready_s = (state_q == S_IDLE) || (state_q == S_RECOVER);
    case (state_q)
      S_IDLE: begin
        if (write) begin
          if (LAT_SKIP) begin
            state_d = S_PRE;
          end else begin
            state_d = S_LAT;
            cnt_d   = LAT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_PRE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PRE: begin
        state_d = S_BURST;
        cnt_d   = BURST_INIT;
      end
      S_BURST: begin
        ack_s = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_POST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_POST: begin
        if (TWR_ZERO) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
          cnt_d   = TWR_INIT;
        end
      end
      S_RECOVER: begin
        // A new write abandons the rest of the recovery window.
        if (write) begin
          if (LAT_SKIP) begin
            state_d = S_PRE;
          end else begin
            state_d = S_LAT;
            cnt_d   = LAT_INIT;
          end
        end else if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output-register inputs: data halves while consuming, idle pattern otherwise
  always_comb begin
    dq_d0_d  = 16'h0000;
    dq_d1_d  = 16'h0000;
    dm_d0_d  = 2'b11;
    dm_d1_d  = 2'b11;
    if (ack_s) begin
      dq_d0_d = din[31:16];
      dq_d1_d = din[15:0];
      dm_d0_d = dmask[3:2];
      dm_d1_d = dmask[1:0];
    end else begin
      dq_d0_d = 16'h0000;
      dq_d1_d = 16'h0000;
    end
    dq_oe_d  = (state_q == S_BURST);
    dqs_en_d = (state_q == S_BURST);
    dqs_oe_d = (state_q == S_PRE) || (state_q == S_BURST) || (state_q == S_POST);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      dq_d0_q  <= 16'h0000;
      dq_d1_q  <= 16'h0000;
      dm_d0_q  <= 2'b11;
      dm_d1_q  <= 2'b11;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_d0_q  <= dq_d0_d;
      dq_d1_q  <= dq_d1_d;
      dm_d0_q  <= dm_d0_d;
      dm_d1_q  <= dm_d1_d;
      dq_oe_q  <= dq_oe_d;
      dqs_oe_q <= dqs_oe_d;
      dqs_en_q <= dqs_en_d;
    end
  end

  assign ready    = ready_s;
  assign wr_err   = write & ~ready_s;
  assign data_ack = ack_s;
  assign idle     = (state_q == S_IDLE);
  assign dq_d0    = dq_d0_q;
  assign dq_d1    = dq_d1_q;
  assign dm_d0    = dm_d0_q;
  assign dm_d1    = dm_d1_q;
  assign dq_oe    = dq_oe_q;
  assign dqs_oe   = dqs_oe_q;
  assign dqs_en   = dqs_en_q;

endmodule

// File: tb/tb_hpdmc_ddrwr_ctl.sv
// Directed bench for hpdmc_ddrwr_ctl: default, short-latency and long-burst parameter sets.
module tb_hpdmc_ddrwr_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        write0, write1, write2;
  logic [31:0] din0, din1, din2;
  logic [3:0]  dmask0, dmask1, dmask2;
  logic        ready0, ready1, ready2, wr_err0, wr_err1, wr_err2;
  logic        ack0, ack1, ack2, oe0, oe1, oe2, soe0, soe1, soe2, sen0, sen1, sen2;
  logic        idle0, idle1, idle2;
  logic [15:0] q0a, q0b, q1a, q1b, q2a, q2b;
  logic [1:0]  m0a, m0b, m1a, m1b, m2a, m2b;

  hpdmc_ddrwr_ctl u0 (
    .sys_clk(clk), .sdram_rst(rst), .write(write0), .ready(ready0), .wr_err(wr_err0),
    .din(din0), .dmask(dmask0), .data_ack(ack0), .dq_d0(q0a), .dq_d1(q0b),
    .dm_d0(m0a), .dm_d1(m0b), .dq_oe(oe0), .dqs_oe(soe0), .dqs_en(sen0), .idle(idle0)
  );

  hpdmc_ddrwr_ctl #(.BURST_LEN(1), .WR_LAT(3), .TWR(0)) u1 (
    .sys_clk(clk), .sdram_rst(rst), .write(write1), .ready(ready1), .wr_err(wr_err1),
    .din(din1), .dmask(dmask1), .data_ack(ack1), .dq_d0(q1a), .dq_d1(q1b),
    .dm_d0(m1a), .dm_d1(m1b), .dq_oe(oe1), .dqs_oe(soe1), .dqs_en(sen1), .idle(idle1)
  );

  hpdmc_ddrwr_ctl #(.BURST_LEN(16), .WR_LAT(1), .TWR(15)) u2 (
    .sys_clk(clk), .sdram_rst(rst), .write(write2), .ready(ready2), .wr_err(wr_err2),
    .din(din2), .dmask(dmask2), .data_ack(ack2), .dq_d0(q2a), .dq_d1(q2b),
    .dm_d0(m2a), .dm_d1(m2b), .dq_oe(oe2), .dqs_oe(soe2), .dqs_en(sen2), .idle(idle2)
  );

  // Packed views: {data_ack, dq_oe, dqs_en, dqs_oe, ready, idle, wr_err} and {dq_d0, dq_d1, dm_d0, dm_d1}
  wire [6:0]  ctl0 = {ack0, oe0, sen0, soe0, ready0, idle0, wr_err0};
  wire [6:0]  ctl1 = {ack1, oe1, sen1, soe1, ready1, idle1, wr_err1};
  wire [6:0]  ctl2 = {ack2, oe2, sen2, soe2, ready2, idle2, wr_err2};
  wire [35:0] dat0 = {q0a, q0b, m0a, m0b};
  wire [35:0] dat1 = {q1a, q1b, m1a, m1b};
  wire [35:0] dat2 = {q2a, q2b, m2a, m2b};

  localparam logic [35:0] DAT_IDLE = {16'h0000, 16'h0000, 2'b11, 2'b11};
  localparam logic [6:0]  CTL_IDLE = 7'b0000110;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    write0 = 1'b0; write1 = 1'b0; write2 = 1'b0;
    din0 = 32'hFFFF_FFFF; din1 = 32'hFFFF_FFFF; din2 = 32'hFFFF_FFFF;
    dmask0 = 4'b0000; dmask1 = 4'b0000; dmask2 = 4'b0000;
    next_cycle();
    next_cycle();
    #3;
    checks++; if (ctl0 !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl0 got %b want %b", ctl0, CTL_IDLE); end
    checks++; if (dat0 !== DAT_IDLE) begin errors++; $display("FAIL reset_dat0 got %h want %h", dat0, DAT_IDLE); end
    checks++; if (ctl1 !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl1 got %b want %b", ctl1, CTL_IDLE); end
    checks++; if (dat1 !== DAT_IDLE) begin errors++; $display("FAIL reset_dat1 got %h want %h", dat1, DAT_IDLE); end
    checks++; if (ctl2 !== CTL_IDLE) begin errors++; $display("FAIL reset_ctl2 got %b want %b", ctl2, CTL_IDLE); end
    checks++; if (dat2 !== DAT_IDLE) begin errors++; $display("FAIL reset_dat2 got %h want %h", dat2, DAT_IDLE); end
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic_burst();
    logic [6:0]  exp_ctl;
    logic [35:0] exp_dat;
    logic        drv;
    for (int c = 0; c <= 10; c++) begin
      write0 = (c == 0);
      din0   = (c >= 2 && c <= 5) ? {16'hA5A5, 16'(c - 1)} : 32'hDEAD_BEEF;
      dmask0 = (c == 3) ? 4'b0110 : 4'b0000;
      #3;
      drv     = (c >= 3 && c <= 6);
      exp_ctl = {(c >= 2 && c <= 5), drv, drv, (c >= 2 && c <= 7),
                 !(c >= 1 && c <= 6), (c == 0 || c >= 9), 1'b0};
      exp_dat = drv ? {16'hA5A5, 16'(c - 2), (c == 4) ? 2'b01 : 2'b00, (c == 4) ? 2'b10 : 2'b00}
                    : DAT_IDLE;
      checks++; if (ctl0 !== exp_ctl) begin errors++; $display("FAIL basic_ctl c=%0d got %b want %b", c, ctl0, exp_ctl); end
      checks++; if (dat0 !== exp_dat) begin errors++; $display("FAIL basic_dat c=%0d got %h want %h", c, dat0, exp_dat); end
      next_cycle();
    end
    write0 = 1'b0;
  endtask

  task automatic test_wr_err_recover();
    logic [6:0]  exp_ctl;
    logic [35:0] exp_dat;
    logic        drv;
    for (int c = 0; c <= 17; c++) begin
      write0 = (c == 0 || c == 3 || c == 7);
      din0   = {16'hB00B, 16'(c)};
      dmask0 = 4'b0000;
      #3;
      drv     = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
      exp_ctl = {(c >= 2 && c <= 5) || (c >= 9 && c <= 12), drv, drv,
                 (c >= 2 && c <= 7) || (c >= 9 && c <= 14),
                 !((c >= 1 && c <= 6) || (c >= 8 && c <= 13)),
                 (c == 0 || c >= 16), (c == 3)};
      exp_dat = drv ? {16'hB00B, 16'(c - 1), 2'b00, 2'b00} : DAT_IDLE;
      checks++; if (ctl0 !== exp_ctl) begin errors++; $display("FAIL wrerr_ctl c=%0d got %b want %b", c, ctl0, exp_ctl); end
      checks++; if (dat0 !== exp_dat) begin errors++; $display("FAIL wrerr_dat c=%0d got %h want %h", c, dat0, exp_dat); end
      next_cycle();
    end
    write0 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    for (int c = 0; c <= 7; c++) begin
      write0 = (c == 0);
      rst    = (c == 4);
      din0   = 32'h5555_AAAA;
      dmask0 = 4'b0000;
      #3;
      if (c >= 5) begin
        checks++; if (ctl0 !== CTL_IDLE) begin errors++; $display("FAIL midrst_ctl c=%0d got %b want %b", c, ctl0, CTL_IDLE); end
        checks++; if (dat0 !== DAT_IDLE) begin errors++; $display("FAIL midrst_dat c=%0d got %h want %h", c, dat0, DAT_IDLE); end
      end
      next_cycle();
    end
    // write coinciding with reset must not start a burst
    write0 = 1'b1;
    rst    = 1'b1;
    next_cycle();
    write0 = 1'b0;
    rst    = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #3;
      checks++; if (ctl0 !== CTL_IDLE) begin errors++; $display("FAIL rstwr_ctl c=%0d got %b want %b", c, ctl0, CTL_IDLE); end
      checks++; if (dat0 !== DAT_IDLE) begin errors++; $display("FAIL rstwr_dat c=%0d got %h want %h", c, dat0, DAT_IDLE); end
      next_cycle();
    end
  endtask

  task automatic test_long_latency_short_burst();
    logic [6:0]  exp_ctl;
    logic [35:0] exp_dat;
    for (int c = 0; c <= 7; c++) begin
      write1 = (c == 0);
      din1   = (c == 4) ? 32'h1357_9BDF : 32'hCAFE_F00D;
      dmask1 = (c == 4) ? 4'b1001 : 4'b0000;
      #3;
      exp_ctl = {(c == 4), (c == 5), (c == 5), (c >= 4 && c <= 6),
                 !(c >= 1 && c <= 5), (c == 0 || c >= 6), 1'b0};
      exp_dat = (c == 5) ? {16'h1357, 16'h9BDF, 2'b10, 2'b01} : DAT_IDLE;
      checks++; if (ctl1 !== exp_ctl) begin errors++; $display("FAIL lat3_ctl c=%0d got %b want %b", c, ctl1, exp_ctl); end
      checks++; if (dat1 !== exp_dat) begin errors++; $display("FAIL lat3_dat c=%0d got %h want %h", c, dat1, exp_dat); end
      next_cycle();
    end
    write1 = 1'b0;
  endtask

  task automatic test_long_burst();
    logic [6:0]  exp_ctl;
    logic [35:0] exp_dat;
    logic        drv;
    int          ack_cnt = 0;
    int          rec_cnt = 0;
    for (int c = 0; c <= 36; c++) begin
      write2 = (c == 0);
      din2   = {16'hF0F0, 16'(c)};
      dmask2 = 4'b0000;
      #3;
      drv     = (c >= 3 && c <= 18);
      exp_ctl = {(c >= 2 && c <= 17), drv, drv, (c >= 2 && c <= 19),
                 !(c >= 1 && c <= 18), (c == 0 || c >= 34), 1'b0};
      exp_dat = drv ? {16'hF0F0, 16'(c - 1), 2'b00, 2'b00} : DAT_IDLE;
      if (ack2 === 1'b1) ack_cnt++;
      if (ready2 === 1'b1 && idle2 === 1'b0) rec_cnt++;
      checks++; if (ctl2 !== exp_ctl) begin errors++; $display("FAIL long_ctl c=%0d got %b want %b", c, ctl2, exp_ctl); end
      checks++; if (dat2 !== exp_dat) begin errors++; $display("FAIL long_dat c=%0d got %h want %h", c, dat2, exp_dat); end
      next_cycle();
    end
    write2 = 1'b0;
    checks++; if (ack_cnt != 16) begin errors++; $display("FAIL long_ack_count got %0d want 16", ack_cnt); end
    checks++; if (rec_cnt != 15) begin errors++; $display("FAIL long_recover_count got %0d want 15", rec_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_wr_err_recover();
    test_reset_mid_burst();
    test_long_latency_short_burst();
    test_long_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
